// File: rtl/phase_freq_detector.sv
// Phase/frequency detector driving an up/down counter; lead width equals edge separation.
// Optional lock detector and lock_o port compiled in with PFD_LOCK_DETECT_EN.
module phase_freq_detector #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LOCK_TOL       = 2,
  parameter int LOCK_COUNT     = 16
) (
  input  logic       fpga_clk_i,
  input  logic       reset_i,
  input  logic       ref_i,
  input  logic       fb_i,
  output logic [1:0] count_instr_o,
  output logic       clear_o,
  output logic       slip_o
`ifdef PFD_LOCK_DETECT_EN
  ,
  output logic       lock_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'b00, REF_LEAD = 2'b01, FB_LEAD = 2'b10} state_e;

  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] err_cnt_q, err_cnt_d, err_inc;
  logic [2:0]  ref_sync_q, fb_sync_q;
  logic [1:0]  arm_q, arm_d;
  logic [1:0]  count_q;
  logic        slip_q, slip_d, clear_q, clear_d;
  logic        ref_rise, fb_rise;

  // Edges are ignored while arm_q counts down so a level already high at reset is not an edge.
  assign ref_rise = ref_sync_q[1] & ~ref_sync_q[2] & (arm_q == 2'd0);
  assign fb_rise  = fb_sync_q[1]  & ~fb_sync_q[2]  & (arm_q == 2'd0);
  assign arm_d    = (arm_q != 2'd0) ? arm_q - 2'd1 : arm_q;
  assign err_inc  = (err_cnt_q >= TO) ? TO : err_cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    slip_d    = 1'b0;
    clear_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_rise && !fb_rise) begin
          state_d   = REF_LEAD;
          err_cnt_d = '0;
        end else if (fb_rise && !ref_rise) begin
          state_d   = FB_LEAD;
          err_cnt_d = '0;
        end
      end
      REF_LEAD: begin
        if (fb_rise) begin
          state_d = IDLE;
        end else if (err_inc == TO) begin
          state_d   = IDLE;
          err_cnt_d = err_inc;
          slip_d    = 1'b1;
          clear_d   = 1'b1;
        end else begin
          err_cnt_d = err_inc;
          slip_d    = ref_rise;
        end
      end
      FB_LEAD: begin
        if (ref_rise) begin
          state_d = IDLE;
        end else if (err_inc == TO) begin
          state_d   = IDLE;
          err_cnt_d = err_inc;
          slip_d    = 1'b1;
          clear_d   = 1'b1;
        end else begin
          err_cnt_d = err_inc;
          slip_d    = fb_rise;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      err_cnt_q  <= '0;
      count_q    <= 2'b00;
      slip_q     <= 1'b0;
      clear_q    <= 1'b1;
      ref_sync_q <= '0;
      fb_sync_q  <= '0;
      arm_q      <= 2'd3;
    end else begin
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      count_q    <= state_d;
      slip_q     <= slip_d;
      clear_q    <= clear_d;
      ref_sync_q <= {ref_sync_q[1:0], ref_i};
      fb_sync_q  <= {fb_sync_q[1:0], fb_i};
      arm_q      <= arm_d;
    end
  end

  assign count_instr_o = count_q;
  assign clear_o       = clear_q;
  assign slip_o        = slip_q;

`ifdef PFD_LOCK_DETECT_EN
  localparam int             LCW  = $clog2(LOCK_COUNT + 1);
  localparam logic [15:0]    TOL  = 16'(LOCK_TOL);
  localparam logic [LCW-1:0] LCNT = LCW'(LOCK_COUNT);

  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           lock_q, lock_d, cmp_done, cmp_ok;

  // A comparison completes when the lagging edge arrives; simultaneous edges in IDLE are width 0.
  always_comb begin
    cmp_done   = ((state_q == IDLE) & ref_rise & fb_rise) |
                 ((state_q == REF_LEAD) & fb_rise) |
                 ((state_q == FB_LEAD) & ref_rise);
    cmp_ok     = (state_q == IDLE) | (err_cnt_q < TOL);
    lock_cnt_d = lock_cnt_q;
    lock_d     = lock_q;
    if (slip_d || (cmp_done && !cmp_ok)) begin
      lock_cnt_d = '0;
      lock_d     = 1'b0;
    end else if (cmp_done) begin
      if (lock_cnt_q != LCNT) lock_cnt_d = lock_cnt_q + LCW'(1);
      lock_d = (lock_cnt_d == LCNT);
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign lock_o = lock_q;
`endif

endmodule

// File: tb/tb_phase_freq_detector.sv
// Directed bench for phase_freq_detector (TIMEOUT_CYCLES=20); waves are per-tick level vectors.
module tb_phase_freq_detector;

  logic       fpga_clk = 1'b0;
  logic       reset, ref_s, fb_s;
  logic [1:0] count_instr;
  logic       clear, slip;
`ifdef PFD_LOCK_DETECT_EN
  logic       lock;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [1:0] code_h  [0:63];
  logic       slip_h  [0:63];
  logic       clear_h [0:63];
  logic       lock_h  [0:63];

  always #5 fpga_clk = ~fpga_clk;

  phase_freq_detector #(.TIMEOUT_CYCLES(20), .LOCK_TOL(2), .LOCK_COUNT(16)) dut (
    .fpga_clk_i    (fpga_clk),
    .reset_i       (reset),
    .ref_i         (ref_s),
    .fb_i          (fb_s),
    .count_instr_o (count_instr),
    .clear_o       (clear),
    .slip_o        (slip)
`ifdef PFD_LOCK_DETECT_EN
    ,
    .lock_o        (lock)
`endif
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge fpga_clk);
    #1;
  endtask

  // Bit i of rw/fw is the input level applied right after tick i (bit 0 before tick 1).
  task automatic run(input logic [63:0] rw, input logic [63:0] fw, input int n);
    for (int i = 0; i < 64; i++) begin
      code_h[i] = 2'b00; slip_h[i] = 1'b0; clear_h[i] = 1'b0; lock_h[i] = 1'b0;
    end
    ref_s = rw[0];
    fb_s  = fw[0];
    for (int i = 1; i <= n; i++) begin
      tick();
      code_h[i]  = count_instr;
      slip_h[i]  = slip;
      clear_h[i] = clear;
`ifdef PFD_LOCK_DETECT_EN
      lock_h[i]  = lock;
`endif
      ref_s = rw[i];
      fb_s  = fw[i];
    end
    ref_s = 1'b0;
    fb_s  = 1'b0;
    repeat (4) tick();
  endtask

  function automatic int cnt_code(input logic [1:0] c);
    int k = 0;
    for (int i = 1; i < 64; i++) if (code_h[i] == c) k++;
    return k;
  endfunction

  function automatic int first_code(input logic [1:0] c);
    for (int i = 1; i < 64; i++) if (code_h[i] == c) return i;
    return -1;
  endfunction

  function automatic int cnt_slip();
    int k = 0;
    for (int i = 1; i < 64; i++) if (slip_h[i]) k++;
    return k;
  endfunction

  initial begin
    reset = 1'b1;
    ref_s = 1'b0;
    fb_s  = 1'b0;

    // Reset held 4 cycles, then released: clear_o covers the first post-reset cycle.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_code", int'(count_instr), 0);
      chk("rst_clear", int'(clear), 1);
    end
    chk("rst_slip", int'(slip), 0);
    reset = 1'b0;
    chk("post_rst_clear_1st", int'(clear), 1);
    tick();
    chk("post_rst_clear_2nd", int'(clear), 0);
    chk("post_rst_code", int'(count_instr), 0);
    repeat (5) tick();

    // ref leads fb by 10 cycles
    run(64'h3FFF, 64'h3C00, 20);
    chk("ref_lead_first", first_code(2'b01), 3);
    chk("ref_lead_width", cnt_code(2'b01), 10);
    chk("ref_lead_no_dn", cnt_code(2'b10), 0);
    chk("ref_lead_slip", cnt_slip(), 0);

    // fb leads ref by 6 cycles
    run(64'h3C0, 64'h3FF, 16);
    chk("fb_lead_first", first_code(2'b10), 3);
    chk("fb_lead_width", cnt_code(2'b10), 6);
    chk("fb_lead_no_up", cnt_code(2'b01), 0);

    // Simultaneous edges
    run(64'h3F, 64'h3F, 12);
    chk("same_up", cnt_code(2'b01), 0);
    chk("same_dn", cnt_code(2'b10), 0);
    chk("same_slip", cnt_slip(), 0);

    // ref with no fb: timeout after 20 lead cycles
    run(64'h3FFF_FFFF, 64'h0, 32);
    chk("to_first", first_code(2'b01), 3);
    chk("to_width", cnt_code(2'b01), 20);
    chk("to_code_after", int'(code_h[23]), 0);
    chk("to_slip", int'(slip_h[23]), 1);
    chk("to_clear", int'(clear_h[23]), 1);
    chk("to_slip_end", int'(slip_h[24]), 0);
    chk("to_clear_end", int'(clear_h[24]), 0);
    chk("to_slip_count", cnt_slip(), 1);

    // Two ref edges before fb: slip pulse while up persists
    run(64'h7FE3, 64'h7C00, 20);
    chk("dbl_width", cnt_code(2'b01), 10);
    chk("dbl_slip_count", cnt_slip(), 1);
    chk("dbl_slip_at8", int'(slip_h[8]), 1);
    chk("dbl_code_at8", int'(code_h[8]), 1);

    // Reset mid-lead aborts; ref held high across reset gives no edge
    ref_s = 1'b1;
    repeat (5) tick();
    chk("mid_code_before", int'(count_instr), 1);
    reset = 1'b1;
    tick();
    chk("mid_code_reset", int'(count_instr), 0);
    chk("mid_clear_reset", int'(clear), 1);
    reset = 1'b0;
    begin
      int nz = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (count_instr != 2'b00) nz++;
      end
      chk("high_at_reset_no_edge", nz, 0);
    end
    ref_s = 1'b0;
    repeat (4) tick();

`ifdef PFD_LOCK_DETECT_EN
    chk("lock_init", int'(lock), 0);
    for (int k = 1; k <= 16; k++) begin
      run(64'hF, 64'hE, 6);
      chk("lock_w1_width", cnt_code(2'b01), 1);
      if (k == 15) chk("lock_after15", int'(lock), 0);
    end
    chk("lock_after16", int'(lock), 1);
    run(64'hFF, 64'hE0, 10);
    chk("lock_w5_before", int'(lock_h[7]), 1);
    chk("lock_w5_drop", int'(lock_h[8]), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
